// File: rtl/cell_test_driver.sv
// cell_test_driver: drives a pseudo-random bit stream into a custom cell,
// samples the cell output after a settle delay, and tallies mismatches
// against the expected inverting or buffering behaviour.
module cell_test_driver #(
    parameter int         CNT_W  = 16,
    parameter int         SETTLE = 2,
    parameter bit         INVERT = 1'b1,
    parameter logic [7:0] SEED   = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vecs,
    output logic             cell_a,
    input  logic             cell_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] vecIdx_q, vecIdx_d;
    logic [CNT_W-1:0] numVecs_q, numVecs_d;
    logic [3:0]       settle_q, settle_d;
    logic             cellA_q, cellA_d;
    logic             exp_q, exp_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] errCount_q, errCount_d;
    logic [CNT_W-1:0] firstErr_q, firstErr_d;

    logic [7:0]       lfsrNext;
    logic [CNT_W-1:0] vecIdxInc;

    assign lfsrNext  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign vecIdxInc = vecIdx_q + ONE;

    // State and datapath registers; reset aborts any run without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED;
            vecIdx_q   <= '0;
            numVecs_q  <= '0;
            settle_q   <= '0;
            cellA_q    <= 1'b0;
            exp_q      <= 1'b0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= '0;
            firstErr_q <= '1;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            vecIdx_q   <= vecIdx_d;
            numVecs_q  <= numVecs_d;
            settle_q   <= settle_d;
            cellA_q    <= cellA_d;
            exp_q      <= exp_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            errCount_q <= errCount_d;
            firstErr_q <= firstErr_d;
        end
    end

    // Next-state logic: one vector is DRIVE, SETTLE cycles of WAIT, then SAMPLE
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        vecIdx_d   = vecIdx_q;
        numVecs_d  = numVecs_q;
        settle_d   = settle_q;
        cellA_d    = cellA_q;
        exp_d      = exp_q;
        busy_d     = busy_q;
        pass_d     = pass_q;
        errCount_d = errCount_q;
        firstErr_d = firstErr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    numVecs_d  = num_vecs;
                    lfsr_d     = SEED;
                    errCount_d = '0;
                    firstErr_d = '1;
                    pass_d     = 1'b0;
                    vecIdx_d   = '0;
                    busy_d     = 1'b1;
                    state_d    = (num_vecs == '0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cellA_d  = lfsr_q[0];
                exp_d    = lfsr_q[0] ^ INVERT;
                settle_d = SETTLE_LD;
                state_d  = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
            end
            ST_WAIT: begin
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (cell_y != exp_q) begin
                    if (errCount_q != '1) begin
                        errCount_d = errCount_q + ONE;
                    end
                    if (firstErr_q == '1) begin
                        firstErr_d = vecIdx_q;
                    end
                end
                lfsr_d   = lfsrNext;
                vecIdx_d = vecIdxInc;
                if (vecIdxInc == numVecs_q) begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                cellA_d = 1'b0;
                busy_d  = 1'b0;
                pass_d  = (errCount_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cell_a        = cellA_q;
    assign busy          = busy_q;
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign err_count     = errCount_q;
    assign first_err_idx = firstErr_q;

endmodule
